gcd_ctrl: RTL and testbench

Sequencing FSM for the GCD datapath. Drives the 4-entry register file's write/read controls, the write-data source mux and the ALU opcode to compute gcd(x, y) by repeated subtraction. It uses status flags fed back from the datapath comparator. A start/busy/done handshake connects it to the top level, and an iteration guard bounds runtime.

---
 rtl/gcd_ctrl_if.sv | 15 +
 rtl/gcd_ctrl.sv | 123 ++++++++++++
 tb/tb_gcd_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gcd_ctrl_if.sv
// gcd_ctrl_if: start/busy/done handshake between the top level and the GCD sequencer
//   start      top -> ctrl  run request
//   busy       ctrl -> top  run in progress
//   done       ctrl -> top  one-cycle completion pulse
//   err        ctrl -> top  iteration limit hit, valid with done
//   iter_count ctrl -> top  subtractions in current/last run
interface gcd_ctrl_if #(parameter int ITER_W = 8);
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic [ITER_W-1:0] iter_count;
    modport master (output start, input busy, done, err, iter_count);
    modport slave  (input start, output busy, done, err, iter_count);
endinterface

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: sequencing FSM computing gcd(x, y) by repeated subtraction on a small datapath
//   clk, reset (async, active-low)
//   a_zero, b_zero, a_eq_b, a_lt_b  comparator flags on rf ports A/B
//   rf_we/rf_wa, rf_rae/rf_raa, rf_rbe/rf_rba  register-file controls (r0 = x, r1 = y, r2 = result)
//   src_sel  write-data mux (0 x_in, 1 y_in, 2 ALU), alu_op (0 A-B, 1 B-A, 2 pass A, 3 pass B)
//   hs       start/busy/done/err/iter_count handshake
module gcd_ctrl #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_zero,
    input  logic       b_zero,
    input  logic       a_eq_b,
    input  logic       a_lt_b,
    output logic       rf_we,
    output logic [2:0] rf_wa,
    output logic       rf_rae,
    output logic       rf_rbe,
    output logic [1:0] rf_raa,
    output logic [1:0] rf_rba,
    output logic [1:0] src_sel,
    output logic [1:0] alu_op,
    gcd_ctrl_if.slave  hs
);
    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, CHECK, SUB_XY, SUB_YX, WRITE_RES, DONE} state_t;

    localparam logic [ITER_W-1:0] MAX = ITER_W'(MAX_ITER);

    state_t            state, state_nx;
    logic [ITER_W-1:0] iter;
    logic              err_q;
    logic              iter_clr, iter_inc, err_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            iter  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (iter_clr)
                iter <= '0;
            else if (iter_inc && iter != MAX)
                iter <= iter + 1'b1;
            if (iter_clr)
                err_q <= 1'b0;
            else if (err_set)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        rf_we    = 1'b0;
        rf_wa    = 3'd0;
        src_sel  = 2'b00;
        alu_op   = 2'b00;
        rf_rae   = 1'b1;
        rf_rbe   = 1'b1;
        rf_raa   = 2'd0;
        rf_rba   = 2'd1;
        iter_clr = 1'b0;
        iter_inc = 1'b0;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                iter_clr = hs.start;
                state_nx = hs.start ? LOAD_X : IDLE;
            end
            LOAD_X: begin
                rf_we    = 1'b1;
                state_nx = LOAD_Y;
            end
            LOAD_Y: begin
                rf_we    = 1'b1;
                rf_wa    = 3'd1;
                src_sel  = 2'b01;
                state_nx = CHECK;
            end
            CHECK: begin
                // Termination outranks the limit so a finished run never reports err.
                err_set  = !(a_zero || b_zero || a_eq_b) && iter == MAX;
                state_nx = (a_zero || b_zero || a_eq_b) ? WRITE_RES :
                           (iter == MAX)                ? DONE      :
                           a_lt_b                       ? SUB_YX    : SUB_XY;
            end
            SUB_XY: begin
                rf_we    = 1'b1;
                src_sel  = 2'b10;
                iter_inc = 1'b1;
                state_nx = CHECK;
            end
            SUB_YX: begin
                rf_we    = 1'b1;
                rf_wa    = 3'd1;
                src_sel  = 2'b10;
                alu_op   = 2'b01;
                iter_inc = 1'b1;
                state_nx = CHECK;
            end
            WRITE_RES: begin
                // Passing the other operand when one is zero covers gcd(0,y), gcd(x,0) and gcd(0,0).
                rf_we    = 1'b1;
                rf_wa    = 3'd2;
                src_sel  = 2'b10;
                alu_op   = a_zero ? 2'b11 : 2'b10;
                state_nx = DONE;
            end
            DONE: begin
                rf_raa   = 2'd2;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign hs.busy       = state != IDLE;
    assign hs.done       = state == DONE;
    assign hs.err        = err_q;
    assign hs.iter_count = iter;
endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: directed bench; two controllers (MAX_ITER 255 and 10) each driving a behavioural datapath
module tb_gcd_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] x_in = '0;
    logic [7:0] y_in = '0;
    logic       start [2];
    logic       done_v [2], busy_v [2], err_v [2], we_v [2], rae_v [2], rbe_v [2];
    logic [7:0] iter_v [2], a_v [2];
    logic [2:0] wa_v [2];
    logic [1:0] op_v [2], sel_v [2], raa_v [2], rba_v [2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : inst
        gcd_ctrl_if #(.ITER_W(8)) hs ();
        logic       rf_we, rf_rae, rf_rbe, a_zero, b_zero, a_eq_b, a_lt_b;
        logic [2:0] rf_wa;
        logic [1:0] rf_raa, rf_rba, src_sel, alu_op;
        logic [7:0] rf [4];
        logic [7:0] a_val, b_val, alu_out, wd;

        assign hs.start = start[g];

        gcd_ctrl #(.ITER_W(8), .MAX_ITER(g == 0 ? 255 : 10)) dut (
            .clk(clk), .reset(reset),
            .a_zero(a_zero), .b_zero(b_zero), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
            .rf_we(rf_we), .rf_wa(rf_wa), .rf_rae(rf_rae), .rf_rbe(rf_rbe),
            .rf_raa(rf_raa), .rf_rba(rf_rba), .src_sel(src_sel), .alu_op(alu_op),
            .hs(hs)
        );

        assign a_val   = rf_rae ? rf[rf_raa] : 8'd0;
        assign b_val   = rf_rbe ? rf[rf_rba] : 8'd0;
        assign a_zero  = a_val == 8'd0;
        assign b_zero  = b_val == 8'd0;
        assign a_eq_b  = a_val == b_val;
        assign a_lt_b  = a_val < b_val;
        assign alu_out = alu_op == 2'b00 ? a_val - b_val :
                         alu_op == 2'b01 ? b_val - a_val :
                         alu_op == 2'b10 ? a_val : b_val;
        assign wd      = src_sel == 2'b00 ? x_in : src_sel == 2'b01 ? y_in : alu_out;

        always_ff @(posedge clk)
            if (rf_we) rf[rf_wa[1:0]] <= wd;

        assign done_v[g] = hs.done;
        assign busy_v[g] = hs.busy;
        assign err_v[g]  = hs.err;
        assign iter_v[g] = hs.iter_count;
        assign a_v[g]    = a_val;
        assign we_v[g]   = rf_we;
        assign wa_v[g]   = rf_wa;
        assign op_v[g]   = alu_op;
        assign sel_v[g]  = src_sel;
        assign rae_v[g]  = rf_rae;
        assign rbe_v[g]  = rf_rbe;
        assign raa_v[g]  = rf_raa;
        assign rba_v[g]  = rf_rba;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // exp_op = -1 means WRITE_RES must never be visited.
    task automatic run(input int g, input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp_r,
                       input logic [7:0] exp_it, input logic exp_err, input int exp_cyc, input int exp_op,
                       input string tag);
        int cyc;
        int wop;
        wop = -1;
        @(negedge clk);
        x_in = x;
        y_in = y;
        start[g] = 1'b1;
        step();
        cyc = 1;
        start[g] = 1'b0;
        while (!done_v[g] && cyc < 2000) begin
            if (we_v[g] && wa_v[g] == 3'd2) wop = int'(op_v[g]);
            step();
            cyc++;
        end
        chk({tag, " done"}, 32'(done_v[g]), 32'd1);
        chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, " result op"}, 32'(wop), 32'(exp_op));
        chk({tag, " r2"}, 32'(a_v[g]), 32'(exp_r));
        chk({tag, " err"}, 32'(err_v[g]), 32'(exp_err));
        chk({tag, " iter"}, 32'(iter_v[g]), 32'(exp_it));
        step();
        chk({tag, " idle busy"}, 32'(busy_v[g]), 32'd0);
        chk({tag, " idle done"}, 32'(done_v[g]), 32'd0);
        chk({tag, " iter hold"}, 32'(iter_v[g]), 32'(exp_it));
    endtask

    initial begin
        int n;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy_v[0]), 32'd0);
        chk("rst done", 32'(done_v[0]), 32'd0);
        chk("rst err", 32'(err_v[0]), 32'd0);
        chk("rst iter", 32'(iter_v[0]), 32'd0);
        chk("rst ctl", {we_v[0], wa_v[0], sel_v[0], op_v[0], rae_v[0], rbe_v[0], raa_v[0], rba_v[0]},
            {1'b0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd0, 2'd1});
        reset = 1'b1;

        // Abort during the first SUB_XY of 48,18.
        x_in = 8'd48;
        y_in = 8'd18;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        n = 0;
        while (!(we_v[0] && wa_v[0] == 3'd0 && sel_v[0] == 2'b10) && n < 20) begin
            step();
            n++;
        end
        chk("reach sub_xy", 32'(n < 20), 32'd1);
        chk("pre-abort iter", 32'(iter_v[0]), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy_v[0]), 32'd0);
        chk("abort we", 32'(we_v[0]), 32'd0);
        chk("abort sel", 32'(sel_v[0]), 32'd0);
        chk("abort iter", 32'(iter_v[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run(0, 8'd9,   8'd3,  8'd3,  8'd2,   1'b0, 9,   2, "9_3");
        run(0, 8'd12,  8'd12, 8'd12, 8'd0,   1'b0, 5,   2, "12_12");
        run(0, 8'd48,  8'd18, 8'd6,  8'd4,   1'b0, 13,  2, "48_18");
        run(0, 8'd0,   8'd7,  8'd7,  8'd0,   1'b0, 5,   3, "0_7");
        run(0, 8'd7,   8'd0,  8'd7,  8'd0,   1'b0, 5,   2, "7_0");
        run(0, 8'd0,   8'd0,  8'd0,  8'd0,   1'b0, 5,   3, "0_0");
        run(0, 8'd255, 8'd1,  8'd1,  8'd254, 1'b0, 513, 2, "255_1");
        run(1, 8'd48,  8'd18, 8'd6,  8'd4,   1'b0, 13,  2, "lim 48_18");
        run(1, 8'd255, 8'd1,  8'd6,  8'd10,  1'b1, 24, -1, "lim 255_1");
        run(1, 8'd5,   8'd10, 8'd5,  8'd1,   1'b0, 7,   2, "lim 5_10");

        // Starts during busy and in DONE are dropped; a start in the following IDLE cycle is taken.
        @(negedge clk);
        x_in = 8'd12;
        y_in = 8'd12;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        step();
        chk("hs done", 32'(done_v[0]), 32'd1);
        chk("hs r2", 32'(a_v[0]), 32'd12);
        start[0] = 1'b1;
        step();
        chk("hs done-start busy", 32'(busy_v[0]), 32'd0);
        chk("hs done-start done", 32'(done_v[0]), 32'd0);
        step();
        chk("hs idle-start busy", 32'(busy_v[0]), 32'd1);
        start[0] = 1'b0;
        n = 0;
        while (!done_v[0] && n < 50) begin
            step();
            n++;
        end
        chk("hs second done", 32'(done_v[0]), 32'd1);
        chk("hs second r2", 32'(a_v[0]), 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
